// File: rtl/exec_pkg.sv
// Shared definitions for the execute/write-back stage.
//   - opcode encodings (4'hB..4'hF are undefined and raise ILLEGAL)
//   - controller state encoding
//   - bit positions inside the {Z,N,C,V} flag word
package exec_pkg;

  localparam logic [3:0] OP_MOV = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_MUL = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Defined opcodes occupy a contiguous range starting at zero.
  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_CMP;
  endfunction

endpackage

// File: rtl/exec_if.sv
// Operand/result bundle between the controller and exec_unit.
//   master (controller): drives start, opcode, src, dest
//   slave  (exec_unit) : drives result, wr, busy, done, flags, illegal
// result/wr are the write-back pair feeding register_file DATA_IN/WR.
interface exec_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] dest;
  logic [WIDTH-1:0] result;
  logic             wr;
  logic             busy;
  logic             done;
  logic [3:0]       flags;
  logic             illegal;

  modport master (
    output start, opcode, src, dest,
    input  result, wr, busy, done, flags, illegal
  );

  modport slave (
    input  start, opcode, src, dest,
    output result, wr, busy, done, flags, illegal
  );
endinterface

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier, one partial product per clock.
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : one-cycle load pulse; clears the accumulator and
//                   loads multiplier/multiplicand, runs WIDTH steps
//   multiplier    : shifted right, bit0 selects the add
//   multiplicand  : shifted left into a 2*WIDTH-bit register
//   done          : high during the final step's cycle
//   product       : accumulator value after the current step; equals
//                   the full 2*WIDTH-bit product while done is high, so
//                   the caller can register it on the same edge
module shift_add_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   count;
  logic               running;

  assign product = mplier[0] ? acc + mcand : acc;
  assign done    = running && (count == CNT_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain the shifts in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      running <= 1'b0;
    end else if (start) begin
      acc     <= '0;
      mcand   <= {{WIDTH{1'b0}}, multiplicand};
      mplier  <= multiplier;
      count   <= CNT_W'(WIDTH);
      running <= 1'b1;
    end else if (running) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CNT_W'(1);
      if (count == CNT_W'(1)) running <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Multi-cycle execute/write-back stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : exec_if slave port
//     start/opcode/src/dest : request, sampled only in IDLE
//     result/wr             : write-back to register_file DATA_IN/WR
//     busy                  : high outside IDLE
//     done/illegal          : one-cycle pulses in WB
//     flags                 : registered {Z,N,C,V}
// ALU ops take IDLE->EXEC->WB; MUL takes IDLE->EXEC->MUL(xWIDTH)->WB.
module exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic  clk,
  input logic  rst_n,
  exec_if.slave bus
);

  state_e           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] src_q;
  logic [WIDTH-1:0] dest_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             wr_q;
  logic             done_q;
  logic             illegal_q;
  logic             busy_q;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [3:0]         alu_flags;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [3:0]         mul_flags;

  assign bus.result  = result_q;
  assign bus.flags   = flags_q;
  assign bus.wr      = wr_q;
  assign bus.done    = done_q;
  assign bus.illegal = illegal_q;
  assign bus.busy    = busy_q;

  // NOTE: every always_comb output gets a default before the case so that
  // undefined opcodes cannot leave a path that infers a latch.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      OP_MOV: alu_res = src_q;
      OP_ADD: begin
        {alu_c, alu_res} = {1'b0, dest_q} + {1'b0, src_q};
        alu_v = (dest_q[WIDTH-1] == src_q[WIDTH-1]) &&
                (alu_res[WIDTH-1] != dest_q[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        // Bit WIDTH of the widened difference is the borrow.
        {alu_c, alu_res} = {1'b0, dest_q} - {1'b0, src_q};
        alu_v = (dest_q[WIDTH-1] != src_q[WIDTH-1]) &&
                (alu_res[WIDTH-1] != dest_q[WIDTH-1]);
      end
      OP_AND: alu_res = dest_q & src_q;
      OP_OR:  alu_res = dest_q | src_q;
      OP_XOR: alu_res = dest_q ^ src_q;
      OP_NOT: alu_res = ~dest_q;
      OP_SHL: begin
        alu_res = {dest_q[WIDTH-2:0], 1'b0};
        alu_c   = dest_q[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, dest_q[WIDTH-1:1]};
        alu_c   = dest_q[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_N] = alu_res[WIDTH-1];
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
  end

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_Z] = (mul_product[WIDTH-1:0] == '0);
    mul_flags[FLAG_N] = mul_product[WIDTH-1];
    mul_flags[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
  end

  // Multiplier from SRC, multiplicand from DEST, loaded during EXEC.
  assign mul_start = (state == ST_EXEC) && (op_q == OP_MUL);

  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (mul_start),
    .multiplier   (src_q),
    .multiplicand (dest_q),
    .done         (mul_done),
    .product      (mul_product)
  );

  // NOTE: only control and datapath registers live here, so all of them take
  // the async reset; an aborted operation can never reach WB and strobe WR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      src_q     <= '0;
      dest_q    <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // Strobes are single-cycle: cleared unless re-asserted on WB entry.
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            op_q   <= bus.opcode;
            src_q  <= bus.src;
            dest_q <= bus.dest;
            busy_q <= 1'b1;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (op_q == OP_MUL) begin
            state <= ST_MUL;
          end else begin
            state  <= ST_WB;
            done_q <= 1'b1;
            if (!is_legal(op_q)) begin
              illegal_q <= 1'b1;
            end else begin
              flags_q <= alu_flags;
              if (op_q != OP_CMP) begin
                result_q <= alu_res;
                wr_q     <= 1'b1;
              end
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state    <= ST_WB;
            done_q   <= 1'b1;
            wr_q     <= 1'b1;
            result_q <= mul_product[WIDTH-1:0];
            flags_q  <= mul_flags;
          end
        end
        ST_WB: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit with a behavioural register_file attached
// (result -> data_in, wr -> wr, addr_b selects the target register).
module tb_exec_unit;
  import exec_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exec_if #(.WIDTH(W)) bus ();

  exec_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural register_file write port.
  logic [2:0]   addr_b;
  logic [W-1:0] regs [8] = '{default: '0};
  int           wr_count = 0;

  always @(posedge clk) begin
    if (bus.wr) begin
      regs[addr_b] <= bus.result;
      wr_count     <= wr_count + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issues one request and returns the number of cycles from the START
  // cycle to the cycle where done is seen (bounded).
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] s, input logic [W-1:0] d,
                        input logic [2:0] a, output int lat);
    @(negedge clk);
    addr_b     = a;
    bus.opcode = op;
    bus.src    = s;
    bus.dest   = d;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] src;
    logic [W-1:0] dest;
    logic [2:0]   addr;
    logic [W-1:0] res;
    logic [3:0]   flags;
    logic         wr;
    logic         ill;
    int           lat;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];
  logic [W-1:0] exp_regs [8] = '{default: '0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int wc;
    int extra_done;
    logic busy_ok;

    bus.start  = 1'b0;
    bus.opcode = '0;
    bus.src    = '0;
    bus.dest   = '0;
    addr_b     = '0;

    //            op      src       dest      addr  result    ZNCV     wr    ill   lat
    vecs[0]  = '{OP_MOV, 16'hA5A5, 16'h0000, 3'd3, 16'hA5A5, 4'b0100, 1'b1, 1'b0, 2};
    vecs[1]  = '{OP_SUB, 16'h0001, 16'h8000, 3'd4, 16'h7FFF, 4'b0001, 1'b1, 1'b0, 2};
    vecs[2]  = '{OP_SUB, 16'h0001, 16'h0000, 3'd4, 16'hFFFF, 4'b0110, 1'b1, 1'b0, 2};
    vecs[3]  = '{OP_AND, 16'hFF00, 16'hF0F0, 3'd5, 16'hF000, 4'b0100, 1'b1, 1'b0, 2};
    vecs[4]  = '{OP_OR,  16'h0F0F, 16'hF0F0, 3'd5, 16'hFFFF, 4'b0100, 1'b1, 1'b0, 2};
    vecs[5]  = '{OP_XOR, 16'hAAAA, 16'hAAAA, 3'd5, 16'h0000, 4'b1000, 1'b1, 1'b0, 2};
    vecs[6]  = '{OP_NOT, 16'h1234, 16'hFFFF, 3'd6, 16'h0000, 4'b1000, 1'b1, 1'b0, 2};
    vecs[7]  = '{OP_ADD, 16'h0001, 16'h7FFF, 3'd6, 16'h8000, 4'b0101, 1'b1, 1'b0, 2};
    vecs[8]  = '{OP_ADD, 16'h0001, 16'hFFFF, 3'd6, 16'h0000, 4'b1010, 1'b1, 1'b0, 2};
    vecs[9]  = '{OP_MUL, 16'h0100, 16'h0100, 3'd7, 16'h0000, 4'b1010, 1'b1, 1'b0, 18};
    vecs[10] = '{OP_MUL, 16'h0003, 16'h5678, 3'd7, 16'h0368, 4'b0010, 1'b1, 1'b0, 18};
    vecs[11] = '{OP_CMP, 16'h5678, 16'h5678, 3'd7, 16'h0368, 4'b1000, 1'b0, 1'b0, 2};
    vecs[12] = '{4'hF,   16'h0002, 16'h0001, 3'd1, 16'h0368, 4'b1000, 1'b0, 1'b1, 2};
    vecs[13] = '{4'hB,   16'h0002, 16'h0001, 3'd2, 16'h0368, 4'b1000, 1'b0, 1'b1, 2};
    vecs[14] = '{OP_MUL, 16'hFFFF, 16'hFFFF, 3'd2, 16'h0001, 4'b0010, 1'b1, 1'b0, 18};

    // ---- reset state ----
    #12;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_wr", 32'(bus.wr), 32'd0);
    check("rst_illegal", 32'(bus.illegal), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_flags", 32'(bus.flags), 32'd0);
    #10 rst_n = 1'b1;

    // ---- ADD: latency, single WR pulse, write-back ----
    run_op(OP_ADD, 16'h1234, 16'h0001, 3'd1, lat);
    check("add_lat", 32'(lat), 32'd2);
    check("add_result", 32'(bus.result), 32'h1235);
    check("add_flags", 32'(bus.flags), 32'h0);
    check("add_wr", 32'(bus.wr), 32'd1);
    exp_regs[1] = 16'h1235;
    @(negedge clk);
    check("add_wr_pulse", 32'(bus.wr), 32'd0);
    check("add_done_pulse", 32'(bus.done), 32'd0);
    check("add_reg", 32'(regs[1]), 32'h1235);

    // ---- async reset in the middle of a MUL ----
    wc = wr_count;
    @(negedge clk);
    addr_b = 3'd2; bus.opcode = OP_MUL; bus.src = 16'h0003; bus.dest = 16'h5678; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #10;
    check("abort_result_in_rst", 32'(bus.result), 32'd0);
    check("abort_busy_in_rst", 32'(bus.busy), 32'd0);
    #10 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_flags", 32'(bus.flags), 32'd0);
    check("abort_no_wr", 32'(wr_count), 32'(wc));
    check("abort_reg", 32'(regs[2]), 32'd0);

    // ---- table-driven operations ----
    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].op, vecs[i].src, vecs[i].dest, vecs[i].addr, lat);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_result", i), 32'(bus.result), 32'(vecs[i].res));
      check($sformatf("v%0d_flags", i), 32'(bus.flags), 32'(vecs[i].flags));
      check($sformatf("v%0d_wr", i), 32'(bus.wr), 32'(vecs[i].wr));
      check($sformatf("v%0d_illegal", i), 32'(bus.illegal), 32'(vecs[i].ill));
      if (vecs[i].wr) exp_regs[vecs[i].addr] = vecs[i].res;
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'd0);
      check($sformatf("v%0d_wr_pulse", i), 32'(bus.wr), 32'd0);
      check($sformatf("v%0d_busy_idle", i), 32'(bus.busy), 32'd0);
      check($sformatf("v%0d_reg", i), 32'(regs[vecs[i].addr]), 32'(exp_regs[vecs[i].addr]));
    end

    // ---- MUL with a stray START while busy ----
    wc = wr_count;
    @(negedge clk);
    addr_b = 3'd4; bus.opcode = OP_MUL; bus.src = 16'h0100; bus.dest = 16'h0100; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!bus.done && lat < 64) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (lat == 4) begin
        bus.start = 1'b1; bus.opcode = OP_ADD; bus.src = 16'h0001; bus.dest = 16'h0001;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check("mulb_lat", 32'(lat), 32'd18);
    check("mulb_busy_throughout", 32'(busy_ok), 32'd1);
    check("mulb_busy_wb", 32'(bus.busy), 32'd1);
    check("mulb_result", 32'(bus.result), 32'h0000);
    check("mulb_flags", 32'(bus.flags), 32'b1010);
    extra_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    check("mulb_no_extra_done", 32'(extra_done), 32'd0);
    check("mulb_one_wr", 32'(wr_count), 32'(wc + 1));
    check("mulb_reg", 32'(regs[4]), 32'h0000);

    // ---- back-to-back shifts ----
    wc = wr_count;
    run_op(OP_SHL, 16'h0000, 16'h8001, 3'd6, lat);
    check("shl_lat", 32'(lat), 32'd2);
    check("shl_result", 32'(bus.result), 32'h0002);
    check("shl_flags", 32'(bus.flags), 32'b0010);
    run_op(OP_SHR, 16'h0000, 16'h8001, 3'd7, lat);
    check("shr_lat", 32'(lat), 32'd2);
    check("shr_result", 32'(bus.result), 32'h4000);
    check("shr_flags", 32'(bus.flags), 32'b0010);
    @(negedge clk);
    check("b2b_reg_shl", 32'(regs[6]), 32'h0002);
    check("b2b_reg_shr", 32'(regs[7]), 32'h4000);
    check("b2b_wr_count", 32'(wr_count), 32'(wc + 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
